user_trap_unit: RTL
===================

USER_TRAP_UNIT -- requirements
Module: user_trap_unit

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- core_clock  in  1  core clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- exc_valid  in  1  synchronous exception request from the decode/execute stage
- exc_cause  in  4  exception code (0..15)
- exc_tval  in  32  trap value (faulting address or instruction)
- cur_pc  in  32  PC of the instruction in execute
- uret_valid  in  1  URET instruction in execute
- ustatus  in  32  current ustatus (bit0 UIE, bit4 UPIE)
- utvec  in  32  current utvec (bits[1:0] mode, bits[31:2] base)
- uepc  in  32  current uepc
- uie  in  32  interrupt enable CSR
- uip  in  32  interrupt pending CSR
- csr_simu_write  out  1  simultaneous uepc/ucause/utval write strobe
- csr_uepc_data, csr_ucause_data, csr_utval_data  out  32 each  data for that strobe
- csr_write  out  1  general CSR write strobe
- csr_write_address  out  12  general CSR write address
- csr_write_data  out  32  general CSR write data
- redirect_valid  out  1  one-cycle PC redirect and pipeline flush
- redirect_pc  out  32  redirect target
- stall  out  1  hold fetch/execute while the sequence runs

Function
REQ-002 The FSM SHALL have states IDLE, TRAP_SAVE, TRAP_STATUS, TRAP_JUMP, RET_STATUS, RET_JUMP.
REQ-003 Event evaluation in IDLE SHALL use fixed priority: exc_valid, then pending interrupt, then uret_valid.
- A pending interrupt is ustatus[0] & |(uie & uip & 32'h111).
REQ-004 Interrupt cause priority SHALL be external (bit8, code 8), then software (bit0, code 0), then timer (bit4, code 4).
REQ-005 On a trap accepted in IDLE, the block SHALL latch:
- cur_pc into epc_q;
- cause_q: {1'b0, 27'b0, exc_cause} for an exception, or {1'b1, 26'b0, code} for an interrupt;
- tval_q: exc_tval for an exception, 0 for an interrupt;
- then go to TRAP_SAVE.
REQ-006 TRAP_SAVE SHALL assert csr_simu_write for exactly one cycle, driving epc_q, cause_q and tval_q; next state TRAP_STATUS.
REQ-007 TRAP_STATUS SHALL assert csr_write for one cycle with csr_write_address 12'd0 and csr_write_data = ustatus with bit4 set to the old bit0 and bit0 cleared; next state TRAP_JUMP.
REQ-008 TRAP_JUMP SHALL assert redirect_valid for one cycle, then return to IDLE. redirect_pc SHALL be:
- {utvec[31:2], 2'b00} + 4*code when utvec[1:0]==2'b01 and cause_q[31]==1 (vectored mode);
- {utvec[31:2], 2'b00} otherwise;
- addition is 32-bit modulo, with no overflow detection.
REQ-009 URET accepted in IDLE SHALL go to RET_STATUS, which asserts csr_write for one cycle with address 12'd0 and data = ustatus with bit0 set to old bit4 and bit4 set to 1; next state RET_JUMP.
REQ-010 RET_JUMP SHALL assert redirect_valid with redirect_pc = {uepc[31:2], 2'b00} for one cycle, then go to IDLE.
REQ-011 stall SHALL be high in every non-IDLE state, and combinationally high in IDLE in the cycle an event is accepted.
REQ-012 exc_valid, uret_valid and interrupt changes SHALL be ignored outside IDLE; callers hold requests until stall falls.
REQ-013 csr_simu_write, csr_write and redirect_valid SHALL be mutually exclusive in every cycle.
REQ-014 A trap sequence SHALL take exactly 3 cycles after acceptance, and a URET sequence exactly 2 cycles.
REQ-015 When exc_valid and uret_valid are both high, the exception SHALL be taken and the URET discarded.
REQ-016 With no events, all strobes SHALL stay low and data outputs SHALL hold their last values.

Reset
REQ-017 While reset_n is low (asserted asynchronously), the FSM SHALL be IDLE, epc_q/cause_q/tval_q SHALL be 0, and all strobe outputs, stall and redirect_pc SHALL be 0.
REQ-018 Reset mid-sequence SHALL abandon the sequence with no further CSR writes or redirect.
REQ-019 The first evaluation after release SHALL be on the first rising edge with reset_n high.

Structure
REQ-020 FSM state encodings, CSR address 12'd0, the UIE/UPIE bit indices and the interrupt codes 0/4/8 SHALL live in the shared config/constants include.
REQ-021 One sub-module, irq_prioritizer (uie, uip, ustatus -> pending, code), SHALL be used.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Exception: exc_cause=2, exc_tval=32'h00000013, cur_pc=32'h00400010, utvec=32'h00400100 -> csr_simu_write with 00400010/00000002/00000013, then ustatus write, then redirect_pc=00400100.
- Vectored timer interrupt: utvec=32'h00400101, ustatus=1, uie=uip=32'h10 -> ucause=80000004, redirect_pc=00400110, written ustatus=32'h10.
- URET: ustatus=32'h10, uepc=32'h00400014 -> ustatus written as 32'h11, redirect_pc=00400014 two cycles after acceptance.
- Simultaneous exc_valid and uret_valid, with interrupt pending -> exception sequence only.
- reset_n low during TRAP_STATUS -> no redirect; outputs 0 immediately.
- Interrupts pending with ustatus[0]=0 -> no activity and stall stays 0.

Source files
------------

// File: rtl/user_trap_unit_pkg.sv
// Shared constants for the user-mode trap unit: FSM encodings, CSR address,
// ustatus bit positions and interrupt codes.
package user_trap_unit_pkg;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_TRAP_SAVE   = 3'd1;
    localparam logic [2:0] ST_TRAP_STATUS = 3'd2;
    localparam logic [2:0] ST_TRAP_JUMP   = 3'd3;
    localparam logic [2:0] ST_RET_STATUS  = 3'd4;
    localparam logic [2:0] ST_RET_JUMP    = 3'd5;

    localparam logic [11:0] CSR_USTATUS_ADDR = 12'd0;

    localparam int unsigned UIE_BIT  = 0;
    localparam int unsigned UPIE_BIT = 4;

    localparam int unsigned IRQ_BIT_SW    = 0;
    localparam int unsigned IRQ_BIT_TIMER = 4;
    localparam int unsigned IRQ_BIT_EXT   = 8;

    localparam logic [4:0] IRQ_CODE_SW    = 5'd0;
    localparam logic [4:0] IRQ_CODE_TIMER = 5'd4;
    localparam logic [4:0] IRQ_CODE_EXT   = 5'd8;

    localparam logic [31:0] IRQ_MASK = 32'h0000_0111;

    // Trap target: vectored mode only applies to interrupts (cause bit 31).
    function automatic logic [31:0] trap_target(input logic [31:0] utvec,
                                                input logic        is_irq,
                                                input logic [4:0]  code);
        logic [31:0] base;
        base = {utvec[31:2], 2'b00};
        if (utvec[1:0] == 2'b01 && is_irq)
            return base + {25'b0, code, 2'b00};
        return base;
    endfunction

endpackage

// File: rtl/user_trap_unit_if.sv
// Pipeline <-> trap unit signal bundle. master = core pipeline/CSR file side,
// slave = trap unit side.
interface user_trap_unit_if;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_tval;
    logic [31:0] cur_pc;
    logic        uret_valid;
    logic [31:0] ustatus;
    logic [31:0] utvec;
    logic [31:0] uepc;
    logic [31:0] uie;
    logic [31:0] uip;

    logic        csr_simu_write;
    logic [31:0] csr_uepc_data;
    logic [31:0] csr_ucause_data;
    logic [31:0] csr_utval_data;
    logic        csr_write;
    logic [11:0] csr_write_address;
    logic [31:0] csr_write_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;

    modport master (
        output exc_valid, exc_cause, exc_tval, cur_pc, uret_valid,
               ustatus, utvec, uepc, uie, uip,
        input  csr_simu_write, csr_uepc_data, csr_ucause_data, csr_utval_data,
               csr_write, csr_write_address, csr_write_data,
               redirect_valid, redirect_pc, stall
    );

    modport slave (
        input  exc_valid, exc_cause, exc_tval, cur_pc, uret_valid,
               ustatus, utvec, uepc, uie, uip,
        output csr_simu_write, csr_uepc_data, csr_ucause_data, csr_utval_data,
               csr_write, csr_write_address, csr_write_data,
               redirect_valid, redirect_pc, stall
    );
endinterface

// File: rtl/user_trap_unit_irq_prioritizer.sv
// Selects the highest-priority enabled, pending user interrupt
// (external > software > timer), gated by ustatus.UIE.
module irq_prioritizer
    import user_trap_unit_pkg::*;
(
    input  logic [31:0] uie,
    input  logic [31:0] uip,
    input  logic [31:0] ustatus,
    output logic        pending,
    output logic [4:0]  code
);
    logic [31:0] active;
    logic        unused_bits;

    assign active      = uie & uip & IRQ_MASK;
    assign unused_bits = ^{ustatus[31:1], active[31:9], active[7:5], active[3:1]};

    // Global enable plus fixed-priority cause encoding
    always_comb begin
        pending = ustatus[UIE_BIT] & (|active);
        code    = IRQ_CODE_SW;
        if (active[IRQ_BIT_EXT])
            code = IRQ_CODE_EXT;
        else if (active[IRQ_BIT_SW])
            code = IRQ_CODE_SW;
        else if (active[IRQ_BIT_TIMER])
            code = IRQ_CODE_TIMER;
    end
endmodule

// File: rtl/user_trap_unit.sv
// User-mode trap/URET sequencer: saves trap context, updates ustatus and
// redirects the PC over a fixed multi-cycle sequence while stalling the core.
module user_trap_unit
    import user_trap_unit_pkg::*;
(
    input  logic             core_clock,
    input  logic             reset_n,
    user_trap_unit_if.slave  bus
);
    logic [2:0]  state_q, state_d;
    logic [31:0] epc_q, cause_q, tval_q;
    logic [31:0] wdata_q, redir_q;
    logic        irq_pending;
    logic [4:0]  irq_code;
    logic        in_idle;
    logic        take_trap;
    logic [31:0] trap_ustatus, ret_ustatus;
    logic [31:0] trap_pc, ret_pc;
    logic        unused_bits;

    irq_prioritizer u_irq_prioritizer (
        .uie     (bus.uie),
        .uip     (bus.uip),
        .ustatus (bus.ustatus),
        .pending (irq_pending),
        .code    (irq_code)
    );

    assign in_idle     = (state_q == ST_IDLE);
    assign take_trap   = bus.exc_valid | irq_pending;
    assign trap_pc     = trap_target(bus.utvec, cause_q[31], cause_q[4:0]);
    assign ret_pc      = {bus.uepc[31:2], 2'b00};
    assign unused_bits = ^{bus.uepc[1:0], cause_q[30:5]};

    // ustatus images written on trap entry and on URET
    always_comb begin
        trap_ustatus           = bus.ustatus;
        trap_ustatus[UPIE_BIT] = bus.ustatus[UIE_BIT];
        trap_ustatus[UIE_BIT]  = 1'b0;
        ret_ustatus            = bus.ustatus;
        ret_ustatus[UIE_BIT]   = bus.ustatus[UPIE_BIT];
        ret_ustatus[UPIE_BIT]  = 1'b1;
    end

    // Next-state logic; events are only sampled in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take_trap)
                    state_d = ST_TRAP_SAVE;
                else if (bus.uret_valid)
                    state_d = ST_RET_STATUS;
            end
            ST_TRAP_SAVE:   state_d = ST_TRAP_STATUS;
            ST_TRAP_STATUS: state_d = ST_TRAP_JUMP;
            ST_TRAP_JUMP:   state_d = ST_IDLE;
            ST_RET_STATUS:  state_d = ST_RET_JUMP;
            ST_RET_JUMP:    state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge core_clock or negedge reset_n) begin
        if (!reset_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Latch trap context on acceptance; exceptions win over interrupts
    always_ff @(posedge core_clock or negedge reset_n) begin
        if (!reset_n) begin
            epc_q   <= '0;
            cause_q <= '0;
            tval_q  <= '0;
        end else if (in_idle && take_trap) begin
            epc_q <= bus.cur_pc;
            if (bus.exc_valid) begin
                cause_q <= {28'b0, bus.exc_cause};
                tval_q  <= bus.exc_tval;
            end else begin
                cause_q <= {1'b1, 26'b0, irq_code};
                tval_q  <= '0;
            end
        end
    end

    // Remember last driven CSR data / redirect target so they hold between sequences
    always_ff @(posedge core_clock or negedge reset_n) begin
        if (!reset_n) begin
            wdata_q <= '0;
            redir_q <= '0;
        end else begin
            case (state_q)
                ST_TRAP_STATUS: wdata_q <= trap_ustatus;
                ST_RET_STATUS:  wdata_q <= ret_ustatus;
                ST_TRAP_JUMP:   redir_q <= trap_pc;
                ST_RET_JUMP:    redir_q <= ret_pc;
                default: ;
            endcase
        end
    end

    // Output strobes and data; live values in the active state, held values otherwise
    always_comb begin
        bus.csr_simu_write    = (state_q == ST_TRAP_SAVE);
        bus.csr_uepc_data     = epc_q;
        bus.csr_ucause_data   = cause_q;
        bus.csr_utval_data    = tval_q;
        bus.csr_write         = (state_q == ST_TRAP_STATUS) || (state_q == ST_RET_STATUS);
        bus.csr_write_address = CSR_USTATUS_ADDR;
        bus.csr_write_data    = wdata_q;
        bus.redirect_valid    = (state_q == ST_TRAP_JUMP) || (state_q == ST_RET_JUMP);
        bus.redirect_pc       = redir_q;
        bus.stall             = !in_idle || take_trap || bus.uret_valid;
        case (state_q)
            ST_TRAP_STATUS: bus.csr_write_data = trap_ustatus;
            ST_RET_STATUS:  bus.csr_write_data = ret_ustatus;
            ST_TRAP_JUMP:   bus.redirect_pc    = trap_pc;
            ST_RET_JUMP:    bus.redirect_pc    = ret_pc;
            default: ;
        endcase
    end
endmodule
